// File: rtl/mips_iter_divider_if.sv
// Handshake and data bundle between the EX-stage controller and the
// iterative divider.
//   master : controller side (drives start/signed/cancel/operands)
//   slave  : divider side (drives busy/done/quotient/remainder)
interface mips_iter_divider_if;
    logic        div_start;
    logic        div_signed;
    logic        div_cancel;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_busy;
    logic        div_done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    modport master (
        output div_start, div_signed, div_cancel, dividend, divisor,
        input  div_busy, div_done, quotient, remainder
    );

    modport slave (
        input  div_start, div_signed, div_cancel, dividend, divisor,
        output div_busy, div_done, quotient, remainder
    );
endinterface

// File: rtl/mips_iter_divider.sv
// Multi-cycle 32-bit DIV/DIVU unit: one restoring radix-2 quotient bit per
// cycle, 32 iterations, registered LO (quotient) / HI (remainder) results.
// Ports:
//   clk    : system clock, rising edge
//   resetn : asynchronous active-low reset
//   dif    : slave side of the divider bundle
//            in : div_start, div_signed, div_cancel, dividend, divisor
//            out: div_busy (iterating), div_done (1-cycle result pulse),
//                 quotient, remainder (hold until next completion)
module mips_iter_divider (
    input  logic               clk,
    input  logic               resetn,
    mips_iter_divider_if.slave dif
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [63:0] pr_q;        // {partial remainder, dividend/quotient bits}
    logic [31:0] dvsr_q;
    logic [31:0] quot_q, rem_q;
    logic        q_neg_q, r_neg_q, dz_q;

    logic        accept, step, last;
    logic [31:0] a_mag, b_mag;
    logic [32:0] trial;
    logic        borrow;
    logic [63:0] pr_next;

    // Cancel always wins over a simultaneous start.
    assign accept = (state_q != BUSY) && dif.div_start && !dif.div_cancel;
    assign step   = (state_q == BUSY) && !dif.div_cancel;
    assign last   = (cnt_q == 6'd31);

    assign a_mag = (dif.div_signed && dif.dividend[31]) ? -dif.dividend : dif.dividend;
    assign b_mag = (dif.div_signed && dif.divisor[31])  ? -dif.divisor  : dif.divisor;

    // Shift left by one, trial-subtract from the upper 33 bits (including
    // the bit shifted out of the top), keep on no borrow.
    assign trial   = pr_q[63:31] - {1'b0, dvsr_q};
    assign borrow  = trial[32];
    assign pr_next = {(borrow ? pr_q[62:31] : trial[31:0]), pr_q[30:0], ~borrow};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY: begin
                if (dif.div_cancel) state_d = IDLE;
                else if (last)      state_d = DONE;
            end
            DONE:    state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            pr_q    <= '0;
            dvsr_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            pr_q    <= {32'd0, a_mag};
            dvsr_q  <= b_mag;
            q_neg_q <= dif.div_signed & (dif.dividend[31] ^ dif.divisor[31]);
            r_neg_q <= dif.div_signed & dif.dividend[31];
            dz_q    <= (dif.divisor == 32'd0);
        end else if (step) begin
            pr_q  <= pr_next;
            cnt_q <= last ? 6'd0 : cnt_q + 6'd1;
            if (last) begin
                // Divide by zero leaves |dividend| in the remainder half, so
                // re-applying the dividend sign restores the original value;
                // only the quotient needs forcing.
                quot_q <= dz_q    ? 32'hFFFF_FFFF :
                          q_neg_q ? -pr_next[31:0] : pr_next[31:0];
                rem_q  <= r_neg_q ? -pr_next[63:32] : pr_next[63:32];
            end
        end
    end

    assign dif.div_busy  = (state_q == BUSY);
    assign dif.div_done  = (state_q == DONE);
    assign dif.quotient  = quot_q;
    assign dif.remainder = rem_q;
endmodule

// File: tb/tb_mips_iter_divider.sv
module tb_mips_iter_divider;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    logic [31:0] last_q = '0, last_r = '0;

    mips_iter_divider_if dif();

    mips_iter_divider dut (
        .clk    (clk),
        .resetn (resetn),
        .dif    (dif)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural DIV/DIVU results from plain arithmetic.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (!sgn) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    // Starts an op in the current cycle N, checks busy N+1..N+32 and the done
    // cycle N+33; returns at the negedge of the done cycle.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        logic [31:0] eq, er;
        int nb, nd;
        ref_div(sgn, a, b, eq, er);
        dif.div_start = 1'b1; dif.div_signed = sgn; dif.dividend = a; dif.divisor = b;
        @(posedge clk); #1;
        dif.div_start  = hold;
        dif.div_signed = 1'($urandom);
        dif.dividend   = $urandom;
        dif.divisor    = $urandom;
        nb = 0; nd = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (dif.div_busy) nb++;
            if (dif.div_done) nd++;
            @(posedge clk); #1;
        end
        dif.div_start = 1'b0;
        @(negedge clk);
        chk({tag, "_busy_cycles"}, nb, 32);
        chk({tag, "_early_done"}, nd, 0);
        chk({tag, "_done"}, {31'd0, dif.div_done}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, dif.div_busy}, 32'd0);
        chk({tag, "_q"}, dif.quotient, eq);
        chk({tag, "_r"}, dif.remainder, er);
        last_q = eq; last_r = er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        dif.div_start = 1'b0; dif.div_signed = 1'b0; dif.div_cancel = 1'b0;
        dif.dividend = '0; dif.divisor = '0;
        #12;
        chk("rst_busy", {31'd0, dif.div_busy}, 32'd0);
        chk("rst_done", {31'd0, dif.div_done}, 32'd0);
        chk("rst_q", dif.quotient, 32'd0);
        chk("rst_r", dif.remainder, 32'd0);
        @(posedge clk); #1; resetn = 1'b1;
        idle(2);

        // Directed cases
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        chk("divu_100_7_lit_q", dif.quotient, 32'h0000_000E);
        chk("divu_100_7_lit_r", dif.remainder, 32'h0000_0002);
        idle(1);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_m7_2_lit_q", dif.quotient, 32'hFFFF_FFFD);
        chk("div_m7_2_lit_r", dif.remainder, 32'hFFFF_FFFF);
        idle(1);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        chk("div_7_m2_lit_r", dif.remainder, 32'h0000_0001);
        idle(1);
        do_div("divu_by0", 1'b0, 32'h1234_5678, 32'd0, 1'b0);
        chk("divu_by0_lit_q", dif.quotient, 32'hFFFF_FFFF);
        idle(1);
        do_div("div_by0_neg", 1'b1, 32'hFFFF_FFF9, 32'd0, 1'b0);
        idle(1);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lit_q", dif.quotient, 32'h8000_0000);
        idle(1);

        // Cancel at N+10 of DIVU 50/5, restart at N+12
        dif.div_start = 1'b1; dif.div_signed = 1'b0; dif.dividend = 32'd50; dif.divisor = 32'd5;
        @(posedge clk); #1; dif.div_start = 1'b0;
        idle(9);
        dif.div_cancel = 1'b1;
        @(posedge clk); #1; dif.div_cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", {31'd0, dif.div_busy}, 32'd0);
        chk("cancel_done", {31'd0, dif.div_done}, 32'd0);
        chk("cancel_q_hold", dif.quotient, last_q);
        chk("cancel_r_hold", dif.remainder, last_r);
        @(posedge clk); #1;
        do_div("after_cancel", 1'b0, 32'd50, 32'd5, 1'b0);
        chk("after_cancel_lit_q", dif.quotient, 32'h0000_000A);
        idle(1);

        // Cancel overrides a simultaneous start in IDLE
        dif.div_start = 1'b1; dif.div_cancel = 1'b1; dif.dividend = 32'd3; dif.divisor = 32'd1;
        @(posedge clk); #1; dif.div_start = 1'b0; dif.div_cancel = 1'b0;
        @(negedge clk);
        chk("cancel_over_start", {31'd0, dif.div_busy}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back with start held high through the second op's BUSY
        do_div("b2b_first", 1'b0, 32'd1000, 32'd10, 1'b0);
        do_div("b2b_second", 1'b0, 32'd9, 32'd4, 1'b1);
        chk("b2b_second_lit_q", dif.quotient, 32'd2);
        chk("b2b_second_lit_r", dif.remainder, 32'd1);
        idle(1);

        // Asynchronous reset mid-BUSY at N+20
        dif.div_start = 1'b1; dif.div_signed = 1'b0; dif.dividend = 32'd77; dif.divisor = 32'd3;
        @(posedge clk); #1; dif.div_start = 1'b0;
        idle(19);
        #2; resetn = 1'b0; #1;
        chk("arst_busy", {31'd0, dif.div_busy}, 32'd0);
        chk("arst_done", {31'd0, dif.div_done}, 32'd0);
        chk("arst_q", dif.quotient, 32'd0);
        chk("arst_r", dif.remainder, 32'd0);
        @(posedge clk); #1; resetn = 1'b1;
        @(negedge clk);
        chk("arst_idle", {31'd0, dif.div_busy}, 32'd0);
        @(posedge clk); #1;
        do_div("post_rst", 1'b0, 32'd1, 32'd1, 1'b0);

        // Randomized operands, modes and gaps
        for (int i = 0; i < 24; i++) begin
            logic        s;
            logic [31:0] a, b;
            int          sel;
            s   = 1'($urandom_range(0, 1));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_div($sformatf("rnd%0d", i), s, a, b, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mips_iter_divider.md
# mips_iter_divider

Multi-cycle 32-bit integer divider for the EX stage, executing MIPS DIV/DIVU. It accepts operands from the register-read path, iterates one quotient bit per cycle, and presents registered quotient/remainder for the HI/LO write path. Those registered values feed the 32-bit 4:1 result-select mux, whose HI/LO inputs come from this block. It also exports a busy flag so the pipeline controller can stall dependent MFHI/MFLO and later divides.

## Interface
- No parameters; data width is fixed at 32.
- clk  input  1  system clock, all state on rising edge
- resetn  input  1  asynchronous, active-low reset
- div_start  input  1  request; accepted only when div_busy=0
- div_signed  input  1  1=DIV (two's complement), 0=DIVU; sampled with div_start
- div_cancel  input  1  synchronous flush from exception/branch kill
- dividend  input  32  rs operand, sampled with div_start
- divisor  input  32  rt operand, sampled with div_start
- div_busy  output  1  high while iterating
- div_done  output  1  one-cycle pulse, results valid and updated
- quotient  output  32  registered LO value
- remainder  output  32  registered HI value

## Operation
- States: IDLE, BUSY, DONE. The 6-bit iteration counter counts 0..31.
- IDLE/DONE with div_start=1 and div_cancel=0: latch the following, then go to BUSY with counter=0.
  - |dividend| and |divisor| as 32-bit unsigned magnitudes (abs only when div_signed).
  - The quotient sign: signs differ, signed op only.
  - The remainder sign: dividend negative, signed op only.
  - A divisor-zero flag.
- BUSY: restoring radix-2 step per cycle on a 64-bit partial remainder. Shift left 1, trial-subtract the divisor from the upper 33 bits, and keep the result if non-negative. The shifted-in quotient bit is the complement of the borrow.
- At the counter=31 step, write the outputs and go to DONE.
  - quotient gets the magnitude quotient, negated if its sign flag is set.
  - remainder gets the magnitude remainder, negated if its sign flag is set.
- Divisor zero (either mode): quotient=0xFFFFFFFF, remainder=original dividend. Full latency still applies.
- Overflow 0x80000000 / 0xFFFFFFFF signed: quotient=0x80000000, remainder=0. This falls out of 32-bit magnitude wrap; no special case.
- DONE: div_done=1 for exactly this cycle. The next state is IDLE, or BUSY if a new start is accepted this cycle.
- quotient/remainder change only on the completion edge and hold until the next completion, including across cancel.
- div_start during BUSY is ignored; the controller must stall.
- div_cancel: from BUSY or DONE, go to IDLE next edge with no done pulse and outputs unchanged. It overrides a simultaneous div_start in any state.
- Operands are sampled only on acceptance; later input changes have no effect.

## Timing
- Reset (resetn low, asynchronous): state=IDLE, counter=0, div_busy=0, div_done=0, quotient=0, remainder=0.
- Latency: start accepted in cycle N gives div_busy=1 in cycles N+1..N+32 and div_done=1 with valid results in cycle N+33.
- Back-to-back: a start in the DONE cycle N+33 is accepted. Throughput is one divide per 33 cycles.
- div_busy and div_done are state-decoded registered outputs; no combinational path from inputs to outputs.
- Reset asserted mid-BUSY aborts immediately. After release the block is in IDLE with zero outputs.

## Test plan
- DIVU 100/7, start at cycle N:
  - div_busy high N+1..N+32.
  - div_done only at N+33.
  - quotient=0x0000000E, remainder=0x00000002.
- DIV 0xFFFFFFF9 (-7) / 0x00000002: quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - Then DIV 7 / 0xFFFFFFFE: quotient=0xFFFFFFFD, remainder=0x00000001.
- Divide by zero:
  - DIVU 0x12345678/0 gives quotient=0xFFFFFFFF, remainder=0x12345678, done at N+33.
  - DIV 0x80000000/0xFFFFFFFF gives quotient=0x80000000, remainder=0.
- Cancel at N+10 of DIVU 50/5:
  - No done pulse; quotient/remainder keep their previous results.
  - Next start at N+12 gives done at N+45, quotient=0xA, remainder=0.
- Back-to-back: assert a new start (DIVU 9/4) in the DONE cycle.
  - Busy starts the next cycle; the second done comes 33 cycles later with quotient=2, remainder=1.
  - div_start held high during BUSY is ignored.
- Pull resetn low at N+20 (asynchronous, mid-cycle):
  - All outputs are 0 immediately and state is IDLE.
  - A post-release DIVU 1/1 gives quotient=1, remainder=0.
